// File: rtl/reg_file_mw_pkg.sv
// Shared constants for the multi-write register file: fixed register
// indices, source addressing-mode encodings and constant-generator values.
package reg_file_mw_pkg;

    // Architectural register indices
    localparam int unsigned PC_IDX  = 0;
    localparam int unsigned SP_IDX  = 1;
    localparam int unsigned SR_IDX  = 2;
    localparam int unsigned CG2_IDX = 3;

    // Width of the byte lane kept by a byte-mode write
    localparam int unsigned BYTE_W = 8;

    // Source addressing modes (As field)
    typedef enum logic [1:0] {
        AS_REG = 2'b00,   // register direct
        AS_IDX = 2'b01,   // indexed
        AS_IND = 2'b10,   // register indirect
        AS_INC = 2'b11    // indirect autoincrement
    } as_mode_e;

    // Constants produced when SA selects R2 (AS_REG reads the real R2)
    localparam int unsigned CG_R2_IDX_VAL = 0;
    localparam int unsigned CG_R2_IND_VAL = 4;
    localparam int unsigned CG_R2_INC_VAL = 8;

    // Constants produced when SA selects R3 (AS_INC yields all ones)
    localparam int unsigned CG_R3_REG_VAL = 0;
    localparam int unsigned CG_R3_IDX_VAL = 1;
    localparam int unsigned CG_R3_IND_VAL = 2;

    // Autoincrement step: word mode steps by 2, byte mode by 1
    function automatic int unsigned inc_amount(input logic word);
        return word ? 2 : 1;
    endfunction

endpackage

// File: rtl/reg_file_mw_cg.sv
// reg_cg_mux: constant-generator substitution on the source read port.
// Ports:
//   sa       - source register address
//   as_mode  - source addressing mode
//   reg_data - register (or bypassed) read data for sa
//   sout_c   - source data after constant substitution (combinational)
module reg_cg_mux
    import reg_file_mw_pkg::*;
#(
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned CG_EN = 1
) (
    input  logic [AW-1:0] sa,
    input  logic [1:0]    as_mode,
    input  logic [DW-1:0] reg_data,
    output logic [DW-1:0] sout_c
);

    if (CG_EN != 0) begin : g_cg
        as_mode_e mode;
        assign mode = as_mode_e'(as_mode);

        // R2/R3 reads are replaced by constants; storage is never touched
        always_comb begin
            sout_c = reg_data;
            if (sa == AW'(SR_IDX)) begin
                case (mode)
                    AS_REG:  sout_c = reg_data;
                    AS_IDX:  sout_c = DW'(CG_R2_IDX_VAL);
                    AS_IND:  sout_c = DW'(CG_R2_IND_VAL);
                    AS_INC:  sout_c = DW'(CG_R2_INC_VAL);
                    default: sout_c = reg_data;
                endcase
            end else if (sa == AW'(CG2_IDX)) begin
                case (mode)
                    AS_REG:  sout_c = DW'(CG_R3_REG_VAL);
                    AS_IDX:  sout_c = DW'(CG_R3_IDX_VAL);
                    AS_IND:  sout_c = DW'(CG_R3_IND_VAL);
                    AS_INC:  sout_c = '1;
                    default: sout_c = reg_data;
                endcase
            end
        end
    end else begin : g_no_cg
        logic unused_cg_inputs;
        assign unused_cg_inputs = ^{sa, as_mode};
        assign sout_c = reg_data;
    end

endmodule

// File: rtl/reg_file_mw.sv
// reg_file_mw: register file with a primary write port, an autoincrement
// write port, PC/SP every-cycle latches and a status-register update port.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   RW, BW, Din, DA    - primary write enable, byte mode, data, destination
//   SA, As             - source address and addressing mode
//   inc_en/reg/word    - autoincrement enable, target register, +2/+1 select
//   PC_in, SP_in       - next PC / SP, latched into R0 / R1 each cycle
//   sr_we, SR_in       - status register (R2) update
//   Sout, Dout         - combinational source / destination read data
//   PC_out/SP_out/SR_out - registered contents of R0, R1, R2
module reg_file_mw
    import reg_file_mw_pkg::*;
#(
    parameter  int unsigned DW     = 16,
    parameter  int unsigned NREGS  = 16,
    parameter  int unsigned CG_EN  = 1,
    parameter  int unsigned BYPASS = 0,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          RW,
    input  logic          BW,
    input  logic [DW-1:0] Din,
    input  logic [AW-1:0] SA,
    input  logic [AW-1:0] DA,
    input  logic [1:0]    As,
    input  logic          inc_en,
    input  logic [AW-1:0] inc_reg,
    input  logic          inc_word,
    input  logic [DW-1:0] PC_in,
    input  logic [DW-1:0] SP_in,
    input  logic          sr_we,
    input  logic [DW-1:0] SR_in,
    output logic [DW-1:0] Sout,
    output logic [DW-1:0] Dout,
    output logic [DW-1:0] PC_out,
    output logic [DW-1:0] SP_out,
    output logic [DW-1:0] SR_out
);

    // Elaboration-time parameter legality
    if (DW != 16 && DW != 20) begin : g_bad_dw
        $error("reg_file_mw: DW must be 16 or 20");
    end
    if (NREGS < 8 || NREGS > 32 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
        $error("reg_file_mw: NREGS must be a power of two in 8..32");
    end

    logic [DW-1:0] regs      [NREGS];
    logic [DW-1:0] next_regs [NREGS];

    logic [DW-1:0] prim_val;
    logic [DW-1:0] inc_val;
    logic [DW-1:0] pc_val;
    logic [DW-1:0] sp_val;
    logic [DW-1:0] src_raw;
    logic [DW-1:0] dst_raw;

    // Bit 0 of PC_in/SP_in is never stored (R0/R1 are always even)
    logic unused_lsbs;
    assign unused_lsbs = ^{PC_in[0], SP_in[0]};

    // Candidate values from each update source
    assign prim_val = BW ? {{(DW - BYTE_W){1'b0}}, Din[BYTE_W-1:0]} : Din;
    assign inc_val  = regs[inc_reg] + DW'(inc_amount(inc_word));
    assign pc_val   = {PC_in[DW-1:1], 1'b0};
    assign sp_val   = {SP_in[DW-1:1], 1'b0};

    // Post-priority next value of every register; unwritten registers hold,
    // so this array doubles as the bypass source.
    always_comb begin
        for (int unsigned i = 0; i < NREGS; i++) begin
            next_regs[i] = regs[i];
            if (rst) begin
                next_regs[i] = '0;
            end else if (RW && DA == AW'(i)) begin
                next_regs[i] = prim_val;
            end else if (inc_en && inc_reg == AW'(i)) begin
                next_regs[i] = inc_val;
            end else if (i == PC_IDX) begin
                next_regs[i] = pc_val;
            end else if (i == SP_IDX) begin
                next_regs[i] = sp_val;
            end else if (i == SR_IDX && sr_we) begin
                next_regs[i] = SR_in;
            end
            if (i == PC_IDX || i == SP_IDX) begin
                next_regs[i][0] = 1'b0;
            end
            // R3 exists only as a constant-generator address
            if (i == CG2_IDX) begin
                next_regs[i] = '0;
            end
        end
    end

    // Storage update
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= next_regs[i];
            end
        end
    end

    // Read ports: optionally forward this cycle's write
    if (BYPASS != 0) begin : g_bypass
        assign src_raw = next_regs[SA];
        assign dst_raw = next_regs[DA];
    end else begin : g_no_bypass
        assign src_raw = regs[SA];
        assign dst_raw = regs[DA];
    end

    reg_cg_mux #(
        .DW    (DW),
        .AW    (AW),
        .CG_EN (CG_EN)
    ) u_cg (
        .sa       (SA),
        .as_mode  (As),
        .reg_data (src_raw),
        .sout_c   (Sout)
    );

    assign Dout   = dst_raw;
    assign PC_out = regs[AW'(PC_IDX)];
    assign SP_out = regs[AW'(SP_IDX)];
    assign SR_out = regs[AW'(SR_IDX)];

endmodule

// File: tb/tb_reg_file_mw.sv
// Directed bench for reg_file_mw: a non-bypass and a bypass instance share
// stimulus; expectations are queued and checked when outputs settle.
module tb_reg_file_mw;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;

    localparam int SEL_DOUT    = 0;
    localparam int SEL_SOUT    = 1;
    localparam int SEL_PC      = 2;
    localparam int SEL_SP      = 3;
    localparam int SEL_SR      = 4;
    localparam int SEL_DOUT_BP = 5;
    localparam int SEL_SOUT_BP = 6;

    logic          clk;
    logic          rst;
    logic          RW, BW, inc_en, inc_word, sr_we;
    logic [DW-1:0] Din, PC_in, SP_in, SR_in;
    logic [AW-1:0] SA, DA, inc_reg;
    logic [1:0]    As;
    logic [DW-1:0] Sout, Dout, PC_out, SP_out, SR_out;
    logic [DW-1:0] Sout_bp, Dout_bp, PC_out_bp, SP_out_bp, SR_out_bp;

    typedef struct {
        string         tag;
        int            sel;
        logic [DW-1:0] exp;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    reg_file_mw #(.DW(DW), .NREGS(16), .CG_EN(1), .BYPASS(0)) dut (
        .clk(clk), .rst(rst), .RW(RW), .BW(BW), .Din(Din), .SA(SA), .DA(DA),
        .As(As), .inc_en(inc_en), .inc_reg(inc_reg), .inc_word(inc_word),
        .PC_in(PC_in), .SP_in(SP_in), .sr_we(sr_we), .SR_in(SR_in),
        .Sout(Sout), .Dout(Dout), .PC_out(PC_out), .SP_out(SP_out), .SR_out(SR_out)
    );

    reg_file_mw #(.DW(DW), .NREGS(16), .CG_EN(1), .BYPASS(1)) dut_bp (
        .clk(clk), .rst(rst), .RW(RW), .BW(BW), .Din(Din), .SA(SA), .DA(DA),
        .As(As), .inc_en(inc_en), .inc_reg(inc_reg), .inc_word(inc_word),
        .PC_in(PC_in), .SP_in(SP_in), .sr_we(sr_we), .SR_in(SR_in),
        .Sout(Sout_bp), .Dout(Dout_bp), .PC_out(PC_out_bp), .SP_out(SP_out_bp),
        .SR_out(SR_out_bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] observe(input int sel);
        case (sel)
            SEL_DOUT:    return Dout;
            SEL_SOUT:    return Sout;
            SEL_PC:      return PC_out;
            SEL_SP:      return SP_out;
            SEL_SR:      return SR_out;
            SEL_DOUT_BP: return Dout_bp;
            SEL_SOUT_BP: return Sout_bp;
            default:     return 'x;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [DW-1:0] e);
        exp_t item;
        item.tag = tag;
        item.sel = sel;
        item.exp = e;
        sb.push_back(item);
    endtask

    // Let combinational outputs settle, then drain the scoreboard
    task automatic settle_check();
        exp_t          e;
        logic [DW-1:0] obs;
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            vectors++;
            assert (obs === e.exp) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RW     = 1'b0;
        BW     = 1'b0;
        inc_en = 1'b0;
        sr_we  = 1'b0;
    endtask

    task automatic peek_reg(input string tag, input logic [AW-1:0] addr,
                            input logic [DW-1:0] e);
        DA = addr;
        push(tag, SEL_DOUT, e);
        settle_check();
    endtask

    initial begin
        rst = 1'b1; RW = 1'b1; BW = 1'b0; Din = 16'h1234; DA = 4'd5; SA = 4'd0;
        As = 2'b00; inc_en = 1'b0; inc_reg = '0; inc_word = 1'b0;
        PC_in = '0; SP_in = '0; sr_we = 1'b0; SR_in = '0;

        // Reset held two cycles with a write pending
        tick();
        push("rst_bypass_dout", SEL_DOUT_BP, 16'h0000);
        settle_check();
        tick();
        rst = 1'b0;
        push("rst_pc", SEL_PC, 16'h0000);
        push("rst_sp", SEL_SP, 16'h0000);
        push("rst_sr", SEL_SR, 16'h0000);
        push("rst_r5", SEL_DOUT, 16'h0000);
        push("release_bypass_r5", SEL_DOUT_BP, 16'h1234);
        settle_check();
        // Write on the first edge after reset commits
        tick();
        idle();
        peek_reg("release_write_r5", 4'd5, 16'h1234);

        // Byte write, then primary/increment collision on the same register
        RW = 1'b1; BW = 1'b1; DA = 4'd6; Din = 16'hABCD;
        tick();
        idle();
        peek_reg("byte_write_r6", 4'd6, 16'h00CD);
        RW = 1'b1; DA = 4'd6; Din = 16'h1111; inc_en = 1'b1; inc_reg = 4'd6;
        tick();
        idle();
        peek_reg("collision_r6", 4'd6, 16'h1111);

        // Primary and increment to different registers commit together
        RW = 1'b1; DA = 4'd8; Din = 16'h0042; inc_en = 1'b1; inc_reg = 4'd6;
        inc_word = 1'b1;
        tick();
        idle();
        peek_reg("dual_r8", 4'd8, 16'h0042);
        peek_reg("dual_r6", 4'd6, 16'h1113);

        // Autoincrement wrap, +2 and +1
        RW = 1'b1; DA = 4'd7; Din = 16'hFFFF;
        tick();
        RW = 1'b1; DA = 4'd9; Din = 16'hFFFF;
        tick();
        idle();
        inc_en = 1'b1; inc_reg = 4'd7; inc_word = 1'b1;
        tick();
        inc_reg = 4'd9; inc_word = 1'b0;
        tick();
        idle();
        peek_reg("wrap_word_r7", 4'd7, 16'h0001);
        peek_reg("wrap_byte_r9", 4'd9, 16'h0000);

        // Status register: sr_we, then primary write outranks sr_we
        sr_we = 1'b1; SR_in = 16'h00A5;
        push("sr_we", SEL_SR, 16'h00A5);
        tick();
        settle_check();
        RW = 1'b1; DA = 4'd2; Din = 16'h0F0F;
        push("sr_prim_wins", SEL_SR, 16'h0F0F);
        tick();
        idle();
        settle_check();

        // Constant generator on R2/R3; R2 keeps its contents
        SA = 4'd2; As = 2'b10; push("cg_r2_10", SEL_SOUT, 16'h0004); settle_check();
        As = 2'b00;            push("cg_r2_00", SEL_SOUT, 16'h0F0F); settle_check();
        As = 2'b01;            push("cg_r2_01", SEL_SOUT, 16'h0000); settle_check();
        SA = 4'd3; As = 2'b11; push("cg_r3_11", SEL_SOUT, 16'hFFFF); settle_check();
        As = 2'b01;            push("cg_r3_01", SEL_SOUT, 16'h0001); settle_check();
        tick();
        push("sr_hold", SEL_SR, 16'h0F0F);
        settle_check();

        // PC latch, primary write outranking it, then latch resumes
        PC_in = 16'h0101;
        push("pc_latch", SEL_PC, 16'h0100);
        tick();
        settle_check();
        RW = 1'b1; DA = 4'd0; Din = 16'h2223;
        push("pc_prim_wins", SEL_PC, 16'h2222);
        tick();
        idle();
        settle_check();
        push("pc_latch_resume", SEL_PC, 16'h0100);
        tick();
        settle_check();

        // SP latch, then autoincrement outranking it (bit 0 forced low)
        SP_in = 16'h0203;
        push("sp_latch", SEL_SP, 16'h0202);
        tick();
        settle_check();
        SP_in = 16'h0300; inc_en = 1'b1; inc_reg = 4'd1; inc_word = 1'b0;
        push("sp_inc_byte", SEL_SP, 16'h0202);
        tick();
        settle_check();
        inc_word = 1'b1;
        push("sp_inc_word", SEL_SP, 16'h0204);
        tick();
        idle();
        settle_check();

        // R3 discards primary and increment writes
        RW = 1'b1; DA = 4'd3; Din = 16'h5555;
        tick();
        idle();
        peek_reg("r3_prim_discard", 4'd3, 16'h0000);
        inc_en = 1'b1; inc_reg = 4'd3;
        tick();
        idle();
        peek_reg("r3_inc_discard", 4'd3, 16'h0000);

        // Bypass: same-cycle forwarding vs one-cycle latency
        RW = 1'b1; DA = 4'd4; SA = 4'd4; As = 2'b00; Din = 16'hBEEF;
        push("bp_sout_same", SEL_SOUT_BP, 16'hBEEF);
        push("bp_dout_same", SEL_DOUT_BP, 16'hBEEF);
        push("nobp_sout_before", SEL_SOUT, 16'h0000);
        settle_check();
        tick();
        idle();
        push("nobp_sout_after", SEL_SOUT, 16'hBEEF);
        settle_check();

        // Constant substitution still overrides a bypassed R2 write
        RW = 1'b1; DA = 4'd2; SA = 4'd2; As = 2'b11; Din = 16'h1234;
        push("bp_cg_override", SEL_SOUT_BP, 16'h0008);
        push("bp_dout_r2", SEL_DOUT_BP, 16'h1234);
        push("nobp_dout_r2", SEL_DOUT, 16'h0F0F);
        settle_check();
        tick();
        idle();
        push("sr_after_write", SEL_SR, 16'h1234);
        settle_check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
